// File: rtl/sram_arbiter_2mb_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_2mb_if
//
// Requester-side handshake bundle for the 2 MB SRAM arbiter.
//
//   Port V (video fetch, read-only):
//     v_req    master->slave  request, held until v_ack
//     v_addr   master->slave  21-bit read address
//     v_ack    slave->master  one-cycle completion pulse
//     v_rdata  slave->master  read data, valid with v_ack, held afterwards
//
//   Port C (CPU/chipset, read/write):
//     c_req    master->slave  request, held until c_ack
//     c_we     master->slave  1 = write, 0 = read
//     c_addr   master->slave  21-bit address
//     c_wdata  master->slave  write data
//     c_ack    slave->master  one-cycle completion pulse
//     c_rdata  slave->master  read data, valid with c_ack, held afterwards
//
// The arbiter uses the slave modport; requesters use the master modport.
// ---------------------------------------------------------------------------
interface sram_arbiter_2mb_if;
    logic        v_req;
    logic [20:0] v_addr;
    logic        v_ack;
    logic [7:0]  v_rdata;

    logic        c_req;
    logic        c_we;
    logic [20:0] c_addr;
    logic [7:0]  c_wdata;
    logic        c_ack;
    logic [7:0]  c_rdata;

    modport slave (
        input  v_req, v_addr, c_req, c_we, c_addr, c_wdata,
        output v_ack, v_rdata, c_ack, c_rdata
    );

    modport master (
        output v_req, v_addr, c_req, c_we, c_addr, c_wdata,
        input  v_ack, v_rdata, c_ack, c_rdata
    );
endinterface

// File: rtl/sram_arbiter_2mb.sv
// ---------------------------------------------------------------------------
// sram_arbiter_2mb
//
// Shares one external 2 MB asynchronous SRAM between a video fetch port (V,
// read-only) and a CPU/chipset port (C, read/write). Every access runs
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE. Video has
// priority, but after MAX_V_BURST consecutive V grants with C waiting, C
// wins the next arbitration.
//
// Ports:
//   clk_100    in     memory clock, all logic on its rising edge
//   reset_n    in     asynchronous active-low reset
//   bus        slave  requester handshakes (see sram_arbiter_2mb_if)
//   SRAM_ADDR  out    21-bit SRAM address (registered)
//   SRAM_DATA  inout  8-bit SRAM data bus, driven only during writes
//   SRAM_WE_n  out    SRAM write strobe, active low (registered)
//
// Parameters:
//   WAIT_CYCLES  strobe width in ACCESS cycles, 1..15
//   MAX_V_BURST  consecutive V grants allowed while C is pending
// ---------------------------------------------------------------------------
module sram_arbiter_2mb #(
    parameter int WAIT_CYCLES = 2,
    parameter int MAX_V_BURST = 4
) (
    input  logic              clk_100,
    input  logic              reset_n,
    sram_arbiter_2mb_if.slave bus,
    output logic [20:0]       SRAM_ADDR,
    inout  wire  [7:0]        SRAM_DATA,
    output logic              SRAM_WE_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int BW = (MAX_V_BURST < 1) ? 1 : $clog2(MAX_V_BURST + 1);
    localparam logic [BW-1:0] MAX_BURST = BW'(MAX_V_BURST);
    localparam logic [3:0]    WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t          state_q,   state_d;
    logic [20:0]     addr_q,    addr_d;     // latched address, drives SRAM_ADDR
    logic            we_q,      we_d;       // latched direction of current access
    logic [7:0]      wdata_q,   wdata_d;    // latched write data
    logic            sel_c_q,   sel_c_d;    // 1 = current access belongs to C
    logic [3:0]      cnt_q,     cnt_d;      // ACCESS down-counter
    logic [BW-1:0]   burst_q,   burst_d;    // consecutive V grants with C waiting
    logic            we_n_q,    we_n_d;
    logic            oe_q,      oe_d;       // data bus output enable
    logic            v_ack_q,   v_ack_d;
    logic            c_ack_q,   c_ack_d;
    logic [7:0]      v_rdata_q, v_rdata_d;
    logic [7:0]      c_rdata_q, c_rdata_d;

    // Strobe and bus enable are registered so the SRAM never sees decode
    // glitches; their async reset releases the bus the moment reset_n falls.
    assign SRAM_ADDR   = addr_q;
    assign SRAM_WE_n   = we_n_q;
    assign SRAM_DATA   = oe_q ? wdata_q : 8'bz;

    assign bus.v_ack   = v_ack_q;
    assign bus.v_rdata = v_rdata_q;
    assign bus.c_ack   = c_ack_q;
    assign bus.c_rdata = c_rdata_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        sel_c_d   = sel_c_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        we_n_d    = we_n_q;
        oe_d      = oe_q;
        v_ack_d   = 1'b0;
        c_ack_d   = 1'b0;
        v_rdata_d = v_rdata_q;
        c_rdata_d = c_rdata_q;

        unique case (state_q)
            IDLE: begin
                we_n_d = 1'b1;
                oe_d   = 1'b0;
                if (bus.v_req && (!bus.c_req || (burst_q < MAX_BURST))) begin
                    // V wins; the counter only tracks V wins that made C wait.
                    state_d = SETUP;
                    sel_c_d = 1'b0;
                    addr_d  = bus.v_addr;
                    we_d    = 1'b0;
                    wdata_d = 8'h00;
                    burst_d = bus.c_req ? (burst_q + BW'(1)) : '0;
                end else if (bus.c_req) begin
                    state_d = SETUP;
                    sel_c_d = 1'b1;
                    addr_d  = bus.c_addr;
                    we_d    = bus.c_we;
                    wdata_d = bus.c_wdata;
                    oe_d    = bus.c_we;
                    burst_d = '0;
                end else begin
                    burst_d = '0;
                end
            end

            SETUP: begin
                state_d = ACCESS;
                cnt_d   = WAIT_LAST;
                we_n_d  = ~we_q;
            end

            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    we_n_d  = 1'b1;
                    if (!we_q) begin
                        if (sel_c_q) c_rdata_d = SRAM_DATA;
                        else         v_rdata_d = SRAM_DATA;
                    end
                    // Acks are registered, so they land in the DONE cycle.
                    c_ack_d = sel_c_q;
                    v_ack_d = ~sel_c_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            DONE: begin
                // Write data is held through DONE and released on return to IDLE.
                state_d = IDLE;
                oe_d    = 1'b0;
            end

            default: begin
                state_d = IDLE;
                we_n_d  = 1'b1;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            sel_c_q   <= 1'b0;
            cnt_q     <= '0;
            burst_q   <= '0;
            we_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            v_ack_q   <= 1'b0;
            c_ack_q   <= 1'b0;
            v_rdata_q <= '0;
            c_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            sel_c_q   <= sel_c_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            we_n_q    <= we_n_d;
            oe_q      <= oe_d;
            v_ack_q   <= v_ack_d;
            c_ack_q   <= c_ack_d;
            v_rdata_q <= v_rdata_d;
            c_rdata_q <= c_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter_2mb.sv
// Directed bench for sram_arbiter_2mb (WAIT_CYCLES=2, MAX_V_BURST=4).
// The SRAM model only drives the data bus when model_oe is set; while it
// drives, any simultaneous drive from the arbiter corrupts the value seen.
module tb_sram_arbiter_2mb;

    logic        clk_100;
    logic        reset_n;
    logic [20:0] sram_addr;
    wire  [7:0]  sram_data;
    logic        sram_we_n;

    logic        model_oe;
    logic [7:0]  model_q;
    int          wr_cnt;
    logic [20:0] wr_addr;
    logic [7:0]  wr_data;

    int total;
    int bad;

    sram_arbiter_2mb_if bus_if ();

    sram_arbiter_2mb #(
        .WAIT_CYCLES (2),
        .MAX_V_BURST (4)
    ) dut (
        .clk_100   (clk_100),
        .reset_n   (reset_n),
        .bus       (bus_if),
        .SRAM_ADDR (sram_addr),
        .SRAM_DATA (sram_data),
        .SRAM_WE_n (sram_we_n)
    );

    assign sram_data = model_oe ? model_q : 8'bz;

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    // Asynchronous SRAM latches the write on the rising edge of WE_n.
    initial wr_cnt = 0;
    always @(posedge sram_we_n) begin
        wr_cnt  = wr_cnt + 1;
        wr_addr = sram_addr;
        wr_data = sram_data;
    end

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        model_q  = 8'h00;
        model_oe = 1'b1;
        #1;
        total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
        total++; if (sram_addr !== 21'h0) begin bad++; $display("FAIL reset_addr: got %h want 000000", sram_addr); end
        total++; if (bus_if.v_ack !== 1'b0 || bus_if.c_ack !== 1'b0) begin bad++; $display("FAIL reset_acks: got v=%b c=%b want 0 0", bus_if.v_ack, bus_if.c_ack); end
        total++; if (bus_if.v_rdata !== 8'h00 || bus_if.c_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got v=%h c=%h want 00 00", bus_if.v_rdata, bus_if.c_rdata); end
        total++; if (sram_data !== 8'h00) begin bad++; $display("FAIL reset_bus_released: got %h want 00", sram_data); end
        model_oe = 1'b0;
        reset_n  = 1'b1;
        tick();
    endtask

    // C write; inputs change after the grant and must be ignored.
    task automatic test_c_write();
        int wr_before;
        wr_before = wr_cnt;
        bus_if.c_req   = 1'b1;
        bus_if.c_we    = 1'b1;
        bus_if.c_addr  = 21'h1ABCD;
        bus_if.c_wdata = 8'h5A;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                bus_if.c_wdata = 8'hFF;
                bus_if.c_addr  = 21'h00000;
                bus_if.c_we    = 1'b0;
            end
            total++; if (sram_addr !== 21'h1ABCD) begin bad++; $display("FAIL wr_addr c%0d: got %h want 01abcd", k, sram_addr); end
            total++; if (sram_we_n !== ((k == 2 || k == 3) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL wr_we_n c%0d: got %b want %b", k, sram_we_n, (k == 2 || k == 3) ? 1'b0 : 1'b1); end
            total++; if (bus_if.c_ack !== (k == 4)) begin bad++; $display("FAIL wr_c_ack c%0d: got %b want %b", k, bus_if.c_ack, k == 4); end
            if (k <= 4) begin
                total++; if (sram_data !== 8'h5A) begin bad++; $display("FAIL wr_data c%0d: got %h want 5a", k, sram_data); end
            end
            if (k == 4) bus_if.c_req = 1'b0;
        end
        model_q  = 8'h00;
        model_oe = 1'b1;
        #1;
        total++; if (sram_data !== 8'h00) begin bad++; $display("FAIL wr_bus_release: got %h want 00", sram_data); end
        model_oe = 1'b0;
        total++; if (wr_cnt !== wr_before + 1) begin bad++; $display("FAIL wr_strobe_count: got %0d want %0d", wr_cnt - wr_before, 1); end
        total++; if (wr_addr !== 21'h1ABCD || wr_data !== 8'h5A) begin bad++; $display("FAIL wr_sram_saw: got %h/%h want 01abcd/5a", wr_addr, wr_data); end
        total++; if (bus_if.c_rdata !== 8'h00) begin bad++; $display("FAIL wr_c_rdata_kept: got %h want 00", bus_if.c_rdata); end
    endtask

    // C read-back; c_wdata is non-zero so any stray drive would show on the bus.
    task automatic test_c_read();
        int wr_before;
        wr_before = wr_cnt;
        model_q  = 8'h5A;
        model_oe = 1'b1;
        bus_if.c_req   = 1'b1;
        bus_if.c_we    = 1'b0;
        bus_if.c_addr  = 21'h1ABCD;
        bus_if.c_wdata = 8'hC3;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL rd_we_n c%0d: got %b want 1", k, sram_we_n); end
            total++; if (sram_data !== 8'h5A) begin bad++; $display("FAIL rd_bus c%0d: got %h want 5a", k, sram_data); end
            total++; if (bus_if.c_ack !== (k == 4)) begin bad++; $display("FAIL rd_c_ack c%0d: got %b want %b", k, bus_if.c_ack, k == 4); end
            if (k >= 4) begin
                total++; if (bus_if.c_rdata !== 8'h5A) begin bad++; $display("FAIL rd_c_rdata c%0d: got %h want 5a", k, bus_if.c_rdata); end
            end
            if (k == 4) bus_if.c_req = 1'b0;
        end
        total++; if (wr_cnt !== wr_before) begin bad++; $display("FAIL rd_no_write: got %0d strobes want 0", wr_cnt - wr_before); end
        model_oe = 1'b0;
    endtask

    task automatic test_v_read_top();
        model_q  = 8'hA5;
        model_oe = 1'b1;
        bus_if.v_req  = 1'b1;
        bus_if.v_addr = 21'h1FFFFF;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++; if (bus_if.v_ack !== (k == 4) || bus_if.c_ack !== 1'b0) begin bad++; $display("FAIL vrd_acks c%0d: got v=%b c=%b want %b 0", k, bus_if.v_ack, bus_if.c_ack, k == 4); end
            if (k == 1) begin
                total++; if (sram_addr !== 21'h1FFFFF) begin bad++; $display("FAIL vrd_addr: got %h want 1fffff", sram_addr); end
            end
            if (k == 4) begin
                total++; if (bus_if.v_rdata !== 8'hA5) begin bad++; $display("FAIL vrd_v_rdata: got %h want a5", bus_if.v_rdata); end
                total++; if (bus_if.c_rdata !== 8'h5A) begin bad++; $display("FAIL vrd_c_rdata_kept: got %h want 5a", bus_if.c_rdata); end
                bus_if.v_req = 1'b0;
            end
        end
        model_oe = 1'b0;
    endtask

    task automatic test_priority();
        logic [9:0] order;
        int         grants;
        int         cyc;
        order  = '0;
        grants = 0;
        cyc    = 0;
        model_q  = 8'h3E;
        model_oe = 1'b1;
        bus_if.v_addr = 21'h00010;
        bus_if.c_addr = 21'h00020;
        bus_if.c_we   = 1'b0;
        bus_if.v_req  = 1'b1;
        bus_if.c_req  = 1'b1;
        while (grants < 10 && cyc < 120) begin
            tick();
            cyc++;
            total++; if (bus_if.v_ack === 1'b1 && bus_if.c_ack === 1'b1) begin bad++; $display("FAIL prio_both_acks cyc%0d: got v=1 c=1 want at most one", cyc); end
            if (bus_if.v_ack === 1'b1 && grants < 10) begin order[grants] = 1'b0; grants++; end
            if (bus_if.c_ack === 1'b1 && grants < 10) begin order[grants] = 1'b1; grants++; end
        end
        bus_if.v_req = 1'b0;
        bus_if.c_req = 1'b0;
        total++; if (grants != 10) begin bad++; $display("FAIL prio_timeout: got %0d grants want 10", grants); end
        for (int i = 0; i < 10; i++) begin
            total++; if (order[i] !== ((i % 5) == 4)) begin bad++; $display("FAIL prio_order g%0d: got %s want %s", i, order[i] ? "C" : "V", ((i % 5) == 4) ? "C" : "V"); end
        end
        total++; if (bus_if.v_rdata !== 8'h3E || bus_if.c_rdata !== 8'h3E) begin bad++; $display("FAIL prio_rdata: got v=%h c=%h want 3e 3e", bus_if.v_rdata, bus_if.c_rdata); end
        tick();
        tick();
        model_oe = 1'b0;
    endtask

    task automatic test_reset_abort();
        bus_if.c_req   = 1'b1;
        bus_if.c_we    = 1'b1;
        bus_if.c_addr  = 21'h00100;
        bus_if.c_wdata = 8'h3C;
        tick();
        tick();
        total++; if (sram_we_n !== 1'b0) begin bad++; $display("FAIL abort_pre_we_n: got %b want 0", sram_we_n); end
        #2;
        reset_n      = 1'b0;
        bus_if.c_req = 1'b0;
        #1;
        total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL abort_we_n: got %b want 1", sram_we_n); end
        total++; if (sram_addr !== 21'h0) begin bad++; $display("FAIL abort_addr: got %h want 000000", sram_addr); end
        model_q  = 8'h00;
        model_oe = 1'b1;
        #1;
        total++; if (sram_data !== 8'h00) begin bad++; $display("FAIL abort_bus_released: got %h want 00", sram_data); end
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (bus_if.c_ack !== 1'b0) begin bad++; $display("FAIL abort_no_ack c%0d: got %b want 0", k, bus_if.c_ack); end
        end
        reset_n = 1'b1;
        total++; if (bus_if.c_rdata !== 8'h00) begin bad++; $display("FAIL abort_c_rdata_reset: got %h want 00", bus_if.c_rdata); end
        // Fresh arbitration after reset: a normal C read.
        model_q        = 8'h77;
        bus_if.c_req   = 1'b1;
        bus_if.c_we    = 1'b0;
        bus_if.c_addr  = 21'h00200;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++; if (bus_if.c_ack !== (k == 4)) begin bad++; $display("FAIL rearb_c_ack c%0d: got %b want %b", k, bus_if.c_ack, k == 4); end
            if (k == 1) begin
                total++; if (sram_addr !== 21'h00200) begin bad++; $display("FAIL rearb_addr: got %h want 000200", sram_addr); end
            end
            if (k == 4) begin
                total++; if (bus_if.c_rdata !== 8'h77) begin bad++; $display("FAIL rearb_c_rdata: got %h want 77", bus_if.c_rdata); end
                bus_if.c_req = 1'b0;
            end
        end
        model_oe = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset_n        = 1'b0;
        model_oe       = 1'b0;
        model_q        = 8'h00;
        bus_if.v_req   = 1'b0;
        bus_if.v_addr  = '0;
        bus_if.c_req   = 1'b0;
        bus_if.c_we    = 1'b0;
        bus_if.c_addr  = '0;
        bus_if.c_wdata = '0;

        test_reset();
        test_c_write();
        test_c_read();
        test_v_read_top();
        test_priority();
        test_reset_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter_2mb.md
Name: sram_arbiter_2mb

Overview:
- Shares the single external 2 MB asynchronous SRAM (21-bit address, 8-bit data, active-low write enable) between two requesters: video fetch (port V, read-only) and CPU/chipset bus (port C, read/write).
- Sequences each SRAM access with fixed setup, strobe and hold phases.
- Arbitrates with video priority and a CPU starvation guard.
- Sits between system_2MB's memory clients and the SRAM_A/SRAM_D/SRAM_WE_n pins.

Parameters:
- WAIT_CYCLES, 2, number of ACCESS-state cycles (strobe width); legal range 1..15.
- MAX_V_BURST, 4, maximum consecutive V grants while C is pending before C must win.

Ports:
- clk_100  input  1  system memory clock; all logic is on its rising edge
- reset_n  input  1  asynchronous active-low reset
- v_req  input  1  video read request; held high until v_ack
- v_addr  input  21  video read address
- v_ack  output  1  one-cycle pulse; v_rdata is valid in the same cycle
- v_rdata  output  8  video read data
- c_req  input  1  CPU request; held high until c_ack
- c_we  input  1  1 = write, 0 = read
- c_addr  input  21  CPU address
- c_wdata  input  8  CPU write data
- c_ack  output  1  one-cycle completion pulse
- c_rdata  output  8  CPU read data, valid with c_ack
- SRAM_ADDR  output  21  SRAM address
- SRAM_DATA  inout  8  SRAM data bus
- SRAM_WE_n  output  1  SRAM write strobe, active low

Behaviour:
- Clock and reset: one clock (clk_100); reset is asynchronous and active-low (reset_n).
- Reset values:
  - state = IDLE
  - SRAM_WE_n = 1
  - SRAM_DATA high-Z
  - SRAM_ADDR = 0
  - v_ack = c_ack = 0
  - v_rdata = c_rdata = 0
  - burst counter = 0
- Reset asserted mid-access: SRAM_WE_n rises and the bus releases immediately (asynchronous). No ack is issued, and the aborted access is not resumed.
- States: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Samples requests.
  - Only v_req: grant V.
  - Only c_req: grant C.
  - Both, with burst counter < MAX_V_BURST: grant V and increment the counter.
  - Both, with burst counter = MAX_V_BURST: grant C.
  - Any C grant, or IDLE with c_req low, clears the counter.
  - On grant: latch the winner's addr, we (V forces 0) and wdata into internal registers, then go to SETUP.
  - No request: stay in IDLE and hold SRAM_ADDR at its last value.
- SETUP (1 cycle):
  - SRAM_ADDR = latched address.
  - Write: SRAM_DATA driven with latched wdata.
  - SRAM_WE_n stays 1.
- ACCESS (WAIT_CYCLES cycles, 4-bit down-counter):
  - Write: SRAM_WE_n = 0 for exactly WAIT_CYCLES cycles and data keeps being driven.
  - Read: SRAM_WE_n = 1 and the bus is high-Z.
  - On the last ACCESS cycle, a read captures SRAM_DATA into the granted port's rdata register.
- DONE (1 cycle):
  - SRAM_WE_n = 1.
  - Write data stays driven (hold); it is released when the next state is entered.
  - The granted port's ack pulses high.
  - Next state is IDLE.
- Latency: req high in IDLE to ack = WAIT_CYCLES + 2 cycles; one access occupies WAIT_CYCLES + 3 cycles including IDLE.
- rdata: holds its value until that port's next read completes. Writes do not alter c_rdata.
- Request changes during an access: changes to addr/wdata/we after the grant are ignored (latched copies are used). A request dropped before its ack still completes and still acks.
- Requester still high after ack: the request is sampled again in the next IDLE and treated as a new request.
- Bus contention: SRAM_DATA is never driven during read SETUP or read ACCESS, so there is no contention.
- Simultaneous acks: v_ack and c_ack are never high in the same cycle.
- Address width: 21 bits, no wrap logic. Address 0x1FFFFF is valid.

Test Plan:
- C write, c_addr=0x1ABCD, c_wdata=0x5A, WAIT_CYCLES=2 -> SRAM_ADDR=0x1ABCD from cycle 1; SRAM_WE_n low in cycles 2–3 only; data 0x5A driven cycles 1–4; c_ack pulse at cycle 4.
- C read back of 0x1ABCD (SRAM model returns 0x5A) -> c_rdata=0x5A with c_ack at cycle 4; SRAM_DATA high-Z throughout; SRAM_WE_n never low.
- v_req and c_req both held continuously, MAX_V_BURST=4 -> grant order V,V,V,V,C,V,V,V,V,C…; no cycle with both acks high.
- Reset_n pulsed low during the ACCESS phase of a write -> SRAM_WE_n=1 and bus high-Z within the same cycle; no c_ack; next IDLE re-arbitrates normally.
- C write with c_wdata changed to 0xFF one cycle after the grant -> SRAM sees 0x5A only.
- V read at 0x1FFFFF (model returns 0xA5) -> v_rdata=0xA5 with v_ack; c_rdata unchanged.
